// File: rtl/sys_arr_result_drain.sv
// Result drain for the systolic array: captures one FP32 result per column and serializes them in column order.
// Optional build macro DRAIN_DENORM_FLUSH_EN flushes denormal results to signed zero and flags underflow.
module sys_arr_result_drain #(
    parameter int N_COLS        = 4,
    parameter int ROW_CNT_W     = 16,
    parameter int SNGL_FLT_SIZE = 32,
    parameter int WORD_W        = SNGL_FLT_SIZE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [ROW_CNT_W-1:0]            cfg_rows,
    input  logic [N_COLS*SNGL_FLT_SIZE-1:0] col_data,
    input  logic [N_COLS-1:0]               col_dirty,
    input  logic [N_COLS*2-1:0]             col_err,
    output logic [N_COLS-1:0]               col_ack,
    output logic [WORD_W-1:0]               m_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic                            m_last,
    output logic [$clog2(N_COLS)-1:0]       m_col,
    output logic                            busy,
    output logic                            done,
    output logic [1:0]                      sticky_err,
    input  logic                            err_clr
);
    localparam int COL_W = $clog2(N_COLS);

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] mantissa;
    } single_float_t;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    state_t                 state;
    state_t                 state_next;
    logic [N_COLS-1:0]      slot_full;
    single_float_t          slot_data [N_COLS];
    single_float_t          cap_word  [N_COLS];
    logic [COL_W-1:0]       rd_col;
    logic [ROW_CNT_W-1:0]   row_cnt;
    logic [ROW_CNT_W-1:0]   row_cnt_inc;
    logic [ROW_CNT_W-1:0]   target;
    logic [1:0]             err_set;
    logic                   handshake;
    logic                   row_done;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (row_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // A slot that empties this cycle still counts as full, so acks only look at registered occupancy.
    assign col_ack     = (state == DRAIN) ? (col_dirty & ~slot_full) : '0;
    assign m_valid     = (state == DRAIN) & slot_full[rd_col];
    assign m_data      = slot_data[rd_col];
    assign m_col       = rd_col;
    assign m_last      = (rd_col == COL_W'(N_COLS - 1));
    assign handshake   = m_valid & m_ready;
    assign row_cnt_inc = row_cnt + ROW_CNT_W'(1);
    assign row_done    = handshake & m_last & (row_cnt_inc == target);

    always_comb begin
        err_set = 2'b00;
        for (int c = 0; c < N_COLS; c++) begin
            cap_word[c] = col_data[c*SNGL_FLT_SIZE +: SNGL_FLT_SIZE];
`ifdef DRAIN_DENORM_FLUSH_EN
            if (cap_word[c].exp == 8'd0 && cap_word[c].mantissa != 23'd0) begin
                cap_word[c].mantissa = 23'd0;
                if (col_ack[c]) begin
                    err_set[0] = 1'b1;
                end
            end
`endif
            if (col_ack[c]) begin
                err_set = err_set | col_err[c*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            slot_full  <= '0;
            rd_col     <= '0;
            row_cnt    <= '0;
            target     <= '0;
            sticky_err <= 2'b00;
            for (int c = 0; c < N_COLS; c++) begin
                slot_data[c] <= '0;
            end
        end else begin
            state      <= state_next;
            sticky_err <= (err_clr ? 2'b00 : sticky_err) | err_set;
            case (state)
                IDLE: begin
                    if (start) begin
                        target  <= (cfg_rows == '0) ? ROW_CNT_W'(1) : cfg_rows;
                        row_cnt <= '0;
                        rd_col  <= '0;
                    end
                end
                DRAIN: begin
                    for (int c = 0; c < N_COLS; c++) begin
                        if (col_ack[c]) begin
                            slot_full[c] <= 1'b1;
                            slot_data[c] <= cap_word[c];
                        end
                    end
                    if (handshake) begin
                        slot_full[rd_col] <= 1'b0;
                        rd_col            <= m_last ? '0 : rd_col + COL_W'(1);
                        if (m_last) begin
                            row_cnt <= row_cnt_inc;
                        end
                    end
                end
                DONE: begin
                    // Anything captured beyond the requested rows is dropped here.
                    slot_full <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sys_arr_result_drain.sv
// Self-checking bench for sys_arr_result_drain: PE-side column queues feed the DUT, a word scoreboard checks the stream.
// Respects DRAIN_DENORM_FLUSH_EN in its reference model.
module tb_sys_arr_result_drain;
    localparam int N  = 4;
    localparam int RW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [RW-1:0]   cfg_rows;
    logic [N*32-1:0] col_data;
    logic [N-1:0]    col_dirty;
    logic [N*2-1:0]  col_err;
    logic [N-1:0]    col_ack;
    logic [31:0]     m_data;
    logic            m_valid;
    logic            m_ready;
    logic            m_last;
    logic [1:0]      m_col;
    logic            busy;
    logic            done;
    logic [1:0]      sticky_err;
    logic            err_clr;

    int vectors     = 0;
    int miscompares = 0;

    // Result queue per column: item_data[c][r] is what column c produces for row r.
    logic [31:0] item_data [N][8];
    logic [1:0]  item_err  [N][8];
    int          pe_delay  [N];
    logic [1:0]  exp_sticky;

    always #5 clk = ~clk;

    sys_arr_result_drain #(.N_COLS(N), .ROW_CNT_W(RW)) dut (
        .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows),
        .col_data(col_data), .col_dirty(col_dirty), .col_err(col_err), .col_ack(col_ack),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_col(m_col),
        .busy(busy), .done(done), .sticky_err(sticky_err), .err_clr(err_clr)
    );

    function automatic logic [31:0] model_value(input logic [31:0] v);
`ifdef DRAIN_DENORM_FLUSH_EN
        if (v[30:23] == 8'd0 && v[22:0] != 23'd0) return {v[31], 31'd0};
`endif
        return v;
    endfunction

    function automatic logic model_flushes(input logic [31:0] v);
`ifdef DRAIN_DENORM_FLUSH_EN
        return (v[30:23] == 8'd0 && v[22:0] != 23'd0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic apply_reset();
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; cfg_rows = '0; col_dirty = '0; col_data = '0;
        col_err = '0; m_ready = 1'b0; err_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_sticky = 2'b00;
        for (int c = 0; c < N; c++) pe_delay[c] = 0;
    endtask

    task automatic fill_items(input int rows, input bit with_err);
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < 8; r++) begin
                item_data[c][r] = $urandom;
                if ($urandom_range(3) == 0) item_data[c][r][30:23] = 8'd0;
                item_err[c][r] = (with_err && $urandom_range(4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            end
        end
        if (rows > 8) $display("[TB] too many rows requested");
    endtask

    // Runs one drain end to end; abort_words>0 returns mid-drain after that many words.
    task automatic run_drain(input int rows_cfg, input int ready_pct, input int dirty_pct,
                             input int stall, input bit clr_first, input int clr_pct, input int abort_words);
        int          rows, total, nwords, it, ec, er;
        int          acked [N];
        int          outs  [N];
        bit          pend  [N];
        bit          prev_stall, exp_valid, clr_now;
        logic [31:0] prev_data, ev;
        logic [N-1:0] exp_ack;
        rows = (rows_cfg == 0) ? 1 : rows_cfg;
        total = rows * N; nwords = 0; it = 0; prev_stall = 0; prev_data = '0;
        for (int c = 0; c < N; c++) begin acked[c] = 0; outs[c] = 0; pend[c] = 0; end
        @(posedge clk); #1;
        cfg_rows = RW'(rows_cfg); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (1) begin
            for (int c = 0; c < N; c++) begin
                if (!pend[c] && acked[c] < rows && it >= pe_delay[c] && $urandom_range(99) < dirty_pct)
                    pend[c] = 1'b1;
                col_dirty[c] = pend[c];
                if (pend[c]) begin
                    col_data[c*32 +: 32] = item_data[c][acked[c]];
                    col_err[c*2 +: 2]    = item_err[c][acked[c]];
                end else begin
                    col_data[c*32 +: 32] = $urandom;
                    col_err[c*2 +: 2]    = 2'($urandom_range(3));
                end
            end
            m_ready = (it >= stall) && ($urandom_range(99) < ready_pct);
            clr_now = (clr_first && it == 0) || ($urandom_range(99) < clr_pct);
            err_clr = clr_now;
            @(negedge clk);
            vectors++;
            if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL busy_in_drain: got %b expected 1", busy); end
            vectors++;
            if (sticky_err !== exp_sticky) begin
                miscompares++; $display("[TB] FAIL sticky_err: got %b expected %b", sticky_err, exp_sticky);
            end
            for (int c = 0; c < N; c++) exp_ack[c] = pend[c] && (acked[c] == outs[c]);
            vectors++;
            if (col_ack !== exp_ack) begin
                miscompares++; $display("[TB] FAIL col_ack: got %b expected %b (cycle %0d)", col_ack, exp_ack, it);
            end
            ec = nwords % N; er = nwords / N;
            exp_valid = (acked[ec] > er);
            vectors++;
            if (m_valid !== exp_valid) begin
                miscompares++; $display("[TB] FAIL m_valid: got %b expected %b (word %0d)", m_valid, exp_valid, nwords);
            end
            if (prev_stall) begin
                vectors++;
                if (m_data !== prev_data) begin
                    miscompares++; $display("[TB] FAIL m_data_stall: got %h expected %h", m_data, prev_data);
                end
            end
            if (exp_valid && m_valid) begin
                ev = model_value(item_data[ec][er]);
                vectors++;
                if (m_data !== ev) begin
                    miscompares++; $display("[TB] FAIL m_data: got %h expected %h (word %0d)", m_data, ev, nwords);
                end
                vectors++;
                if (m_col !== 2'(ec)) begin
                    miscompares++; $display("[TB] FAIL m_col: got %0d expected %0d", m_col, ec);
                end
                vectors++;
                if (m_last !== (ec == N - 1)) begin
                    miscompares++; $display("[TB] FAIL m_last: got %b expected %b", m_last, (ec == N - 1));
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (clr_now) exp_sticky = 2'b00;
            for (int c = 0; c < N; c++) begin
                if (exp_ack[c]) begin
                    exp_sticky = exp_sticky | item_err[c][acked[c]] | {1'b0, model_flushes(item_data[c][acked[c]])};
                    acked[c]++;
                    pend[c] = 1'b0;
                end
            end
            if (exp_valid && m_ready) begin outs[ec]++; nwords++; end
            it++;
            if (abort_words > 0 && nwords >= abort_words) return;
            if (nwords == total) break;
            if (it > 3000) begin
                vectors++; miscompares++;
                $display("[TB] FAIL drain_timeout: got %0d words expected %0d", nwords, total);
                return;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        col_dirty = '0; m_ready = 1'b0; err_clr = 1'b0;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL done_pulse: got %b expected 1", done); end
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL busy_in_done: got %b expected 0", busy); end
        vectors++;
        if (sticky_err !== exp_sticky) begin
            miscompares++; $display("[TB] FAIL sticky_end: got %b expected %b", sticky_err, exp_sticky);
        end
        @(posedge clk); #1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_one_cycle: got %b expected 0", done); end
        vectors++;
        if (busy !== 1'b0 || m_valid !== 1'b0) begin
            miscompares++; $display("[TB] FAIL idle_after_done: got busy=%b m_valid=%b expected 0 0", busy, m_valid);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        vectors++; if (col_ack !== '0)    begin miscompares++; $display("[TB] FAIL rst_col_ack: got %b expected 0", col_ack); end
        vectors++; if (m_valid !== 1'b0)  begin miscompares++; $display("[TB] FAIL rst_m_valid: got %b expected 0", m_valid); end
        vectors++; if (m_last !== 1'b0)   begin miscompares++; $display("[TB] FAIL rst_m_last: got %b expected 0", m_last); end
        vectors++; if (busy !== 1'b0)     begin miscompares++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (done !== 1'b0)     begin miscompares++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
        vectors++; if (m_col !== 2'd0)    begin miscompares++; $display("[TB] FAIL rst_m_col: got %0d expected 0", m_col); end
        vectors++; if (m_data !== 32'd0)  begin miscompares++; $display("[TB] FAIL rst_m_data: got %h expected 0", m_data); end
        vectors++; if (sticky_err !== 2'b00) begin miscompares++; $display("[TB] FAIL rst_sticky: got %b expected 00", sticky_err); end
    endtask

    task automatic test_single_row();
        apply_reset();
        fill_items(1, 1'b0);
        item_data[0][0] = 32'h3F800000; item_data[1][0] = 32'h40000000;
        item_data[2][0] = 32'h40400000; item_data[3][0] = 32'h40800000;
        run_drain(1, 100, 100, 0, 1'b0, 0, 0);
    endtask

    task automatic test_back_pressure();
        apply_reset();
        fill_items(2, 1'b0);
        item_data[0][0] = 32'h3F800000;
        run_drain(2, 100, 100, 11, 1'b0, 0, 0);
    endtask

    task automatic test_out_of_order();
        apply_reset();
        fill_items(1, 1'b0);
        pe_delay[0] = 3; pe_delay[1] = 3; pe_delay[2] = 3; pe_delay[3] = 0;
        run_drain(1, 100, 100, 0, 1'b0, 0, 0);
    endtask

    task automatic test_errors();
        apply_reset();
        fill_items(1, 1'b0);
        for (int c = 0; c < N; c++) item_data[c][0] = 32'h3F800000 + 32'(c);
        item_err[2][0] = 2'b10;
        run_drain(1, 100, 100, 0, 1'b0, 0, 0);
        vectors++;
        if (sticky_err !== 2'b10) begin miscompares++; $display("[TB] FAIL err_capture: got %b expected 10", sticky_err); end
        @(posedge clk); #1; err_clr = 1'b1;
        @(posedge clk); #1; err_clr = 1'b0;
        exp_sticky = 2'b00;
        @(negedge clk);
        vectors++;
        if (sticky_err !== 2'b00) begin miscompares++; $display("[TB] FAIL err_clear: got %b expected 00", sticky_err); end
        run_drain(1, 100, 100, 0, 1'b0, 0, 0);
        item_err[2][0] = 2'b00;
        item_err[1][0] = 2'b01;
        run_drain(1, 100, 100, 0, 1'b1, 0, 0);
        vectors++;
        if (sticky_err !== 2'b01) begin miscompares++; $display("[TB] FAIL err_clr_vs_capture: got %b expected 01", sticky_err); end
    endtask

    task automatic test_reset_mid_drain();
        apply_reset();
        fill_items(3, 1'b1);
        run_drain(3, 80, 80, 0, 1'b0, 0, 5);
        test_reset();
        fill_items(1, 1'b0);
        run_drain(0, 100, 100, 0, 1'b0, 0, 0);
    endtask

    task automatic test_denorm();
        apply_reset();
        fill_items(1, 1'b0);
        item_data[0][0] = 32'h80000001; item_data[1][0] = 32'h3F800000;
        item_data[2][0] = 32'h40000000; item_data[3][0] = 32'h40400000;
        run_drain(1, 100, 100, 0, 1'b0, 0, 0);
        vectors++;
`ifdef DRAIN_DENORM_FLUSH_EN
        if (sticky_err !== 2'b01) begin miscompares++; $display("[TB] FAIL denorm_sticky: got %b expected 01", sticky_err); end
`else
        if (sticky_err !== 2'b00) begin miscompares++; $display("[TB] FAIL denorm_sticky: got %b expected 00", sticky_err); end
`endif
    endtask

    task automatic test_random();
        int rows;
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            rows = $urandom_range(0, 4);
            fill_items(rows, 1'b1);
            run_drain(rows, 60, 50, 0, 1'b0, 5, 0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_rows = '0; col_data = '0; col_dirty = '0;
        col_err = '0; m_ready = 1'b0; err_clr = 1'b0; exp_sticky = 2'b00;
        for (int c = 0; c < N; c++) pe_delay[c] = 0;
        test_reset();
        test_single_row();
        test_back_pressure();
        test_out_of_order();
        test_errors();
        test_reset_mid_drain();
        test_denorm();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
